// File: rtl/uart_tx.sv
// UART serial transmitter: accepts one word over valid/ready and shifts it out
// as start, LSB-first data, optional parity and 1-2 stop bits on baud_tick.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line at mark, tx_ready high, waiting for a transfer
// ARM    | word latched, line at mark, waiting for a tick boundary
// START  | start bit (0) on the line
// DATA   | data bits on the line, LSB first
// PARITY | parity bit on the line
// STOP   | stop bit(s) (1) on the line; final tick returns to IDLE
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        stop_d  = stop_q;

        case (state_q)
            S_IDLE: begin
                // Transfer ignores baud_tick so the start bit is always a full period.
                if (tx_valid) begin
                    state_d = S_ARM;
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ ODD_BIT;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            S_ARM: begin
                if (baud_tick) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (idx_q < IDX_LAST) begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else if (PARITY_EN != 0) begin
                        state_d = S_PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (STOP_BITS == 2 && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
        end
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 8O1) driven with random
// words and checked against an expected-frame model built from the bit rules.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic [2:0] v;
    logic [2:0] tx_w, ready_w, busy_w, done_w;

    int tests = 0;
    int fails = 0;
    int sel   = 0;
    int tick_cnt;

    logic tx_s, ready_s, busy_s, done_s;

    always #5 clk = ~clk;

    // One tick every 4 clk, updated just after the rising edge.
    initial begin
        baud_tick = 1'b0;
        tick_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt  = (tick_cnt + 1) % 4;
            baud_tick = (tick_cnt == 0);
        end
    end

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(v[0]), .tx_ready(ready_w[0]), .tx(tx_w[0]),
        .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(v[1]), .tx_ready(ready_w[1]), .tx(tx_w[1]),
        .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(v[2]), .tx_ready(ready_w[2]), .tx(tx_w[2]),
        .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    always_comb begin
        tx_s    = tx_w[sel];
        ready_s = ready_w[sel];
        busy_s  = busy_w[sel];
        done_s  = done_w[sel];
    end

    function automatic int frame_len(input int s);
        return 1 + 8 + ((s != 0) ? 1 : 0) + ((s == 1) ? 2 : 1);
    endfunction

    // Expected line levels, one entry per bit period, frame bit 0 = start.
    function automatic logic [15:0] model_frame(input int s, input logic [7:0] d);
        logic [15:0] f;
        int n;
        logic p;
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        n = 9;
        if (s != 0) begin
            p = ($countones(d) % 2) == 1;
            if (s == 2) p = ~p;
            f[n] = p;
            n++;
        end
        for (int i = 0; i < ((s == 1) ? 2 : 1); i++) f[n+i] = 1'b1;
        return f;
    endfunction

    task automatic do_accept(input logic [7:0] d, output bit ok);
        @(negedge clk);
        tx_data = d;
        v[sel]  = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ready_s === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // Samples the line on falling edges from just after a transfer to one
    // cycle past the final stop bit; reports what it saw, checks nothing.
    task automatic capture(output logic [15:0] bits, output int mark, output int done_cnt,
                           output bit ready_low, output bit busy_high, output bit stable,
                           output bit done_end, output bit ready_end, output bit tx_end);
        int n;
        n = frame_len(sel);
        bits = '0; mark = 0; done_cnt = 0;
        ready_low = 1'b1; busy_high = 1'b1; stable = 1'b1;
        done_end = 1'b0; ready_end = 1'b0; tx_end = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_s === 1'b0 || mark > 40) break;
            mark++;
            ready_low &= (ready_s === 1'b0);
            busy_high &= (busy_s === 1'b1);
            if (done_s === 1'b1) done_cnt++;
        end
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < 4; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (k == 0) bits[b] = tx_s;
                else stable &= (tx_s === bits[b]);
                ready_low &= (ready_s === 1'b0);
                busy_high &= (busy_s === 1'b1);
                if (done_s === 1'b1) done_cnt++;
            end
        end
        @(negedge clk);
        done_end  = (done_s === 1'b1);
        ready_end = (ready_s === 1'b1);
        tx_end    = (tx_s === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; v = '0; tx_data = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            tests++;
            if ({tx_w[s], ready_w[s], busy_w[s], done_w[s]} !== 4'b1100) begin
                fails++;
                $display("FAIL reset_outputs inst=%0d got tx/rdy/busy/done=%b want 1100", s,
                         {tx_w[s], ready_w[s], busy_w[s], done_w[s]});
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                tests++;
                if ({tx_w[s], ready_w[s], busy_w[s], done_w[s]} !== 4'b1100) begin
                    fails++;
                    $display("FAIL idle_after_reset inst=%0d cyc=%0d got %b want 1100", s, c,
                             {tx_w[s], ready_w[s], busy_w[s], done_w[s]});
                end
            end
        end
    endtask

    task automatic test_single_frame(input int s, input logic [7:0] d);
        bit ok, rl, bh, st, de, re, te;
        logic [15:0] bits, exp;
        int mark, dc;
        sel = s;
        exp = model_frame(s, d);
        do_accept(d, ok);
        v[s] = 1'b0;
        fork
            capture(bits, mark, dc, rl, bh, st, de, re, te);
            begin
                repeat (7) @(negedge clk);
                tx_data = 8'($urandom);
            end
        join
        tests++;
        if (!ok) begin fails++; $display("FAIL accept inst=%0d got ready timeout want accepted", s); end
        tests++;
        if (mark < 1 || mark > 4) begin
            fails++; $display("FAIL start_latency inst=%0d got %0d clk want 1..4", s, mark);
        end
        tests++;
        if (bits !== exp) begin
            fails++; $display("FAIL frame_bits inst=%0d data=%h got %b want %b", s, d, bits, exp);
        end
        tests++;
        if (!st) begin fails++; $display("FAIL bit_width inst=%0d got unstable bit want 4 clk each", s); end
        tests++;
        if (!rl || !bh) begin
            fails++; $display("FAIL busy_ready inst=%0d got ready_low=%0b busy_high=%0b want 1 1", s, rl, bh);
        end
        tests++;
        if (dc != 0 || !de) begin
            fails++; $display("FAIL done_pulse inst=%0d got early=%0d end=%0b want 0 1", s, dc, de);
        end
        tests++;
        if (!re || !te) begin
            fails++; $display("FAIL end_idle inst=%0d got ready=%0b tx=%0b want 1 1", s, re, te);
        end
        @(negedge clk);
        tests++;
        if (done_s !== 1'b0) begin
            fails++; $display("FAIL done_width inst=%0d got %b want 0", s, done_s);
        end
    endtask

    task automatic test_basic();
        test_single_frame(0, 8'hA5);
    endtask

    task automatic test_parity();
        test_single_frame(1, 8'h07);
        test_single_frame(2, 8'h07);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            for (int s = 0; s < 3; s++) test_single_frame(s, 8'($urandom));
        end
        test_single_frame(0, 8'h00);
        test_single_frame(1, 8'hFF);
        test_single_frame(2, 8'hFF);
    endtask

    task automatic test_back_to_back();
        bit ok, rl1, bh1, st1, de1, re1, te1, rl2, bh2, st2, de2, re2, te2;
        logic [15:0] b1, b2;
        int m1, m2, dc1, dc2;
        sel = 0;
        do_accept(8'h55, ok);
        fork
            capture(b1, m1, dc1, rl1, bh1, st1, de1, re1, te1);
            begin
                repeat (9) @(negedge clk);
                tx_data = 8'hFF;
            end
        join
        fork
            capture(b2, m2, dc2, rl2, bh2, st2, de2, re2, te2);
            begin
                @(posedge clk);
                #1;
                v[0] = 1'b0;
                repeat (8) @(negedge clk);
                tx_data = 8'($urandom);
            end
        join
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b_accept got ready timeout want accepted"); end
        tests++;
        if (b1 !== model_frame(0, 8'h55) || !st1) begin
            fails++; $display("FAIL b2b_frame1 got %b stable=%0b want %b", b1, st1, model_frame(0, 8'h55));
        end
        tests++;
        if (!rl1 || !de1) begin
            fails++; $display("FAIL b2b_ready_low1 got ready_low=%0b done=%0b want 1 1", rl1, de1);
        end
        tests++;
        if (m2 < 1 || m2 > 4) begin
            fails++; $display("FAIL b2b_gap got %0d clk of ARM mark want 1..4", m2);
        end
        tests++;
        if (b2 !== model_frame(0, 8'hFF) || !st2) begin
            fails++; $display("FAIL b2b_frame2 got %b stable=%0b want %b", b2, st2, model_frame(0, 8'hFF));
        end
        tests++;
        if (!de2 || !re2 || dc2 != 0) begin
            fails++; $display("FAIL b2b_done2 got end=%0b ready=%0b early=%0d want 1 1 0", de2, re2, dc2);
        end
        repeat (6) @(negedge clk);
        tests++;
        if (ready_s !== 1'b1 || busy_s !== 1'b0) begin
            fails++; $display("FAIL b2b_no_third got ready=%b busy=%b want 1 0", ready_s, busy_s);
        end
    endtask

    task automatic test_coincident();
        bit rl, bh, st, de, re, te;
        logic [15:0] bits;
        logic [7:0] d;
        int mark, dc, guard;
        sel = 0;
        d = 8'($urandom);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (baud_tick !== 1'b1 && guard < 10);
        tx_data = d;
        v[0] = 1'b1;
        tests++;
        if (ready_s !== 1'b1) begin fails++; $display("FAIL coinc_ready got %b want 1", ready_s); end
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        capture(bits, mark, dc, rl, bh, st, de, re, te);
        tests++;
        if (mark != 4) begin fails++; $display("FAIL coinc_arm_wait got %0d clk want 4", mark); end
        tests++;
        if (bits !== model_frame(0, d) || !st) begin
            fails++; $display("FAIL coinc_frame got %b stable=%0b want %b", bits, st, model_frame(0, d));
        end
        tests++;
        if (!de) begin fails++; $display("FAIL coinc_done got 0 want 1"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] d;
        int cnt;
        sel = 0;
        d = 8'($urandom) & 8'hF7;
        do_accept(d, ok);
        v[0] = 1'b0;
        tests++;
        if (!ok) begin fails++; $display("FAIL rstmid_accept got ready timeout want accepted"); end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (tx_s !== 1'b0 && cnt < 20);
        tests++;
        if (tx_s !== 1'b0) begin fails++; $display("FAIL rstmid_start got tx=%b want 0", tx_s); end
        repeat (17) @(negedge clk);
        tests++;
        if (tx_s !== d[3]) begin fails++; $display("FAIL rstmid_bit3 got %b want %b", tx_s, d[3]); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({tx_s, ready_s, busy_s, done_s} !== 4'b1100) begin
            fails++; $display("FAIL rstmid_async got tx/rdy/busy/done=%b want 1100",
                              {tx_s, ready_s, busy_s, done_s});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_single_frame(0, 8'h3C);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_random();
        test_back_to_back();
        test_coincident();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
